pendulum_step_ctrl: RTL and testbench

PENDULUM_STEP_CTRL -- requirements
Module: pendulum_step_ctrl

---
 rtl/pendulum_step_ctrl_pkg.sv | 30 +++
 rtl/pendulum_step_ctrl_if.sv | 41 ++++
 rtl/pendulum_watchdog.sv | 39 +++
 rtl/pendulum_step_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pendulum_step_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pendulum_step_ctrl_pkg.sv
// Shared definitions for the pendulum step controller: FSM encoding, word width,
// default episode/timeout sizes and the IEEE-754 constants used by the datapaths.
// No logic; imported by the interface, watchdog and controller.
package pendulum_step_ctrl_pkg;

   localparam int WL_DEF        = 32;
   localparam int MAX_STEPS_DEF = 200;
   localparam int TIMEOUT_DEF   = 64;

   // Single-precision constants shared with the thdot/theta datapaths.
   localparam logic [31:0] F_MAX_SPEED = 32'h4100_0000;   //  8.0
   localparam logic [31:0] F_MIN_SPEED = 32'hC100_0000;   // -8.0
   localparam logic [31:0] F_DT        = 32'h3D4C_CCCD;   //  0.05

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_ACT,
      ST_RUN_THD,
      ST_RUN_TH,
      ST_OBS,
      ST_DONE,
      ST_ERR
   } state_t;

   // Increment that sticks at lim.
   function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
      return (v >= lim) ? lim : v + 8'd1;
   endfunction

endpackage

// File: rtl/pendulum_step_ctrl_if.sv
// Handshake/bus bundle between the step controller (master) and its environment
// (slave): action in, thdot/theta datapath launches and results, observation out.
// Ports: act_*, thd_*, th_*, obs_*, committed th/thdot.
interface pendulum_step_ctrl_if #(
   parameter int WL = 32
);
   // action handshake
   logic          act_valid;
   logic          act_ready;
   logic [WL-1:0] tor;
   // thdot datapath
   logic          thd_ena;
   logic [WL-1:0] thd_th;
   logic [WL-1:0] thd_thdot;
   logic [WL-1:0] thd_tor;
   logic          thd_valid;
   logic [WL-1:0] thd_data;
   // theta datapath
   logic          th_ena;
   logic [WL-1:0] th_thdot;
   logic          th_valid;
   logic [WL-1:0] th_data;
   // observation handshake and committed state
   logic          obs_valid;
   logic          obs_ready;
   logic [WL-1:0] th;
   logic [WL-1:0] thdot;

   modport master (
      output act_ready, thd_ena, thd_th, thd_thdot, thd_tor,
             th_ena, th_thdot, obs_valid, th, thdot,
      input  act_valid, tor, thd_valid, thd_data, th_valid, th_data, obs_ready
   );

   modport slave (
      input  act_ready, thd_ena, thd_th, thd_thdot, thd_tor,
             th_ena, th_thdot, obs_valid, th, thdot,
      output act_valid, tor, thd_valid, thd_data, th_valid, th_data, obs_ready
   );

endinterface

// File: rtl/pendulum_watchdog.sv
// Purpose: per-launch cycle watchdog for the step controller's compute phases.
// Latency: o_expired is combinational, high in the TIMEOUT-1'th cycle after a load.
// Backpressure: none; counts while i_run, cleared when idle, reloaded on i_load.
// Ports: i_clk, i_rst_n, i_load (launch pulse), i_run (compute phase), o_expired.
module pendulum_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_run,
   output logic o_expired
);

   localparam int             CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // The launch cycle itself is cycle 0, so a load leaves 1 for the next cycle;
   // cycle k then holds k and expiry fires in cycle TIMEOUT-1, making the
   // registered fault visible exactly TIMEOUT cycles after the launch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (i_load) begin
         cnt <= CW'(1);
      end else if (!i_run) begin
         cnt <= '0;
      end else if (cnt != LIMIT) begin
         cnt <= cnt + CW'(1);
      end
   end

   // The load cycle is masked: in the first theta cycle cnt still carries the
   // thdot-phase count.
   assign o_expired = i_run && !i_load && (cnt == LIMIT);

endmodule

// File: rtl/pendulum_step_ctrl.sv
// Purpose: sequences one pendulum env step: action -> thdot launch -> theta launch -> obs.
// Latency: 1 cycle from action handshake / thd result / th result to the next launch/obs.
// Backpressure: act_ready only in WAIT_ACT; obs_valid held until obs_ready; RUN_* wait on results.
// Ports: i_clk, i_rst_n (async, active-low), i_init + i_init_th/i_init_thdot (episode start),
//        bus (pendulum_step_ctrl_if.master), o_step_cnt, o_done, o_err.
// Option: PENDULUM_WATCHDOG_EN adds a per-launch timeout into ERR; without it o_err stays 0.
module pendulum_step_ctrl
   import pendulum_step_ctrl_pkg::*;
#(
   parameter int WL        = WL_DEF,
   parameter int MAX_STEPS = MAX_STEPS_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_init,
   input  logic [WL-1:0]        i_init_th,
   input  logic [WL-1:0]        i_init_thdot,
   pendulum_step_ctrl_if.master bus,
   output logic [7:0]           o_step_cnt,
   output logic                 o_done,
   output logic                 o_err
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

   if (MAX_STEPS < 1 || MAX_STEPS > 255 || TIMEOUT < 2) begin : g_bad_cfg
      $error("pendulum_step_ctrl: MAX_STEPS must be 1..255 and TIMEOUT >= 2");
   end

   state_t        state;
   logic [WL-1:0] th_q, thdot_q, tor_q, shadow_q;
   logic [7:0]    step_cnt_q;
   logic          act_ready_q, thd_ena_q, th_ena_q, obs_valid_q;
   logic          done_q, err_q;
   // A launched datapath still owes a result after an abort; the flag drops
   // that late result even if it lands after the next launch of the same unit.
   logic          stale_thd, stale_th;
   logic          thd_take, th_take, wd_expired;

   assign thd_take = (state == ST_RUN_THD) && bus.thd_valid && !stale_thd;
   assign th_take  = (state == ST_RUN_TH)  && bus.th_valid  && !stale_th;

`ifdef PENDULUM_WATCHDOG_EN
   logic wd_run;
   assign wd_run = (state == ST_RUN_THD) || (state == ST_RUN_TH);

   pendulum_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (thd_ena_q | th_ena_q),
      .i_run     (wd_run),
      .o_expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         th_q        <= '0;
         thdot_q     <= '0;
         tor_q       <= '0;
         shadow_q    <= '0;
         step_cnt_q  <= '0;
         act_ready_q <= 1'b0;
         thd_ena_q   <= 1'b0;
         th_ena_q    <= 1'b0;
         obs_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         stale_thd   <= 1'b0;
         stale_th    <= 1'b0;
      end else begin
         thd_ena_q <= 1'b0;
         th_ena_q  <= 1'b0;
         if (bus.thd_valid) stale_thd <= 1'b0;
         if (bus.th_valid)  stale_th  <= 1'b0;

         // Episode start/abort outranks everything except the fault state,
         // including an action offered in the same cycle.
         if (i_init && state != ST_ERR) begin
            state       <= ST_WAIT_ACT;
            th_q        <= i_init_th;
            thdot_q     <= i_init_thdot;
            shadow_q    <= '0;
            step_cnt_q  <= '0;
            act_ready_q <= 1'b1;
            obs_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            // One owed result is tracked per unit; a second abort before the
            // first late result arrives is not distinguished.
            stale_thd   <= (state == ST_RUN_THD) && !thd_take;
            stale_th    <= (state == ST_RUN_TH)  && !th_take;
         end else begin
            case (state)
               ST_WAIT_ACT: begin
                  if (bus.act_valid && act_ready_q) begin
                     tor_q       <= bus.tor;
                     thd_ena_q   <= 1'b1;
                     act_ready_q <= 1'b0;
                     state       <= ST_RUN_THD;
                  end
               end
               ST_RUN_THD: begin
                  if (thd_take) begin
                     shadow_q <= bus.thd_data;
                     th_ena_q <= 1'b1;
                     state    <= ST_RUN_TH;
                  end else if (wd_expired) begin
                     err_q <= 1'b1;
                     state <= ST_ERR;
                  end
               end
               ST_RUN_TH: begin
                  // th and thdot commit together so observers never see a torn state.
                  if (th_take) begin
                     th_q        <= bus.th_data;
                     thdot_q     <= shadow_q;
                     step_cnt_q  <= sat_inc(step_cnt_q, MAX_CNT);
                     obs_valid_q <= 1'b1;
                     state       <= ST_OBS;
                  end else if (wd_expired) begin
                     err_q <= 1'b1;
                     state <= ST_ERR;
                  end
               end
               ST_OBS: begin
                  if (bus.obs_ready) begin
                     obs_valid_q <= 1'b0;
                     if (step_cnt_q == MAX_CNT) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                     end else begin
                        act_ready_q <= 1'b1;
                        state       <= ST_WAIT_ACT;
                     end
                  end
               end
               ST_IDLE, ST_DONE, ST_ERR: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Operands come straight from committed state and the latched torque, which
   // only change on commit/handshake, so they hold from launch to result.
   assign bus.act_ready = act_ready_q;
   assign bus.thd_ena   = thd_ena_q;
   assign bus.thd_th    = th_q;
   assign bus.thd_thdot = thdot_q;
   assign bus.thd_tor   = tor_q;
   assign bus.th_ena    = th_ena_q;
   assign bus.th_thdot  = shadow_q;
   assign bus.obs_valid = obs_valid_q;
   assign bus.th        = th_q;
   assign bus.thdot     = thdot_q;
   assign o_step_cnt    = step_cnt_q;
   assign o_done        = done_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_pendulum_step_ctrl.sv
// Directed bench for pendulum_step_ctrl (MAX_STEPS=3, TIMEOUT=64): reset, full steps,
// obs stall, episode end, abort with stale results, init/action collision, watchdog, reset.
// Inputs are driven 1ns after the rising edge; outputs are sampled at the same point.
module tb_pendulum_step_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init = 1'b0;
   logic [31:0] init_th = '0;
   logic [31:0] init_thdot = '0;
   logic [7:0]  step_cnt;
   logic        done, err;

   int n_tests = 0;
   int n_fail  = 0;
   int n_thd   = 0;
   int n_th    = 0;

   pendulum_step_ctrl_if #(.WL(32)) bus ();

   pendulum_step_ctrl #(.WL(32), .MAX_STEPS(3), .TIMEOUT(64)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_init       (init),
      .i_init_th    (init_th),
      .i_init_thdot (init_thdot),
      .bus          (bus),
      .o_step_cnt   (step_cnt),
      .o_done       (done),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   // Launch pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.thd_ena) n_thd++;
      if (bus.th_ena)  n_th++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200us");
      $fatal(1, "bench timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init(input logic [31:0] th0, input logic [31:0] thdot0);
      init_th = th0; init_thdot = thdot0; init = 1'b1;
      tick();
      init = 1'b0;
   endtask

   task automatic handshake(input logic [31:0] tor);
      bus.tor = tor; bus.act_valid = 1'b1;
      tick();
      bus.act_valid = 1'b0;
   endtask

   task automatic thd_result(input logic [31:0] d);
      bus.thd_data = d; bus.thd_valid = 1'b1;
      tick();
      bus.thd_valid = 1'b0;
   endtask

   task automatic th_result(input logic [31:0] d);
      bus.th_data = d; bus.th_valid = 1'b1;
      tick();
      bus.th_valid = 1'b0;
   endtask

   task automatic obs_ack();
      bus.obs_ready = 1'b1;
      tick();
      bus.obs_ready = 1'b0;
   endtask

   task automatic run_step(input logic [31:0] tor, input logic [31:0] thd, input logic [31:0] th);
      handshake(tor);
      tick();
      thd_result(thd);
      tick();
      th_result(th);
      check_eq("step_obs_valid", 32'(bus.obs_valid), 1);
      check_eq("step_th", bus.th, th);
      check_eq("step_thdot", bus.thdot, thd);
      obs_ack();
   endtask

   initial begin
      int snap_thd, snap_th, hold_bad;
      bus.act_valid = 0; bus.tor = '0; bus.thd_valid = 0; bus.thd_data = '0;
      bus.th_valid = 0; bus.th_data = '0; bus.obs_ready = 0;

      // ---- reset state, no launch before init
      repeat (3) tick();
      check_eq("rst_act_ready", 32'(bus.act_ready), 0);
      check_eq("rst_obs_valid", 32'(bus.obs_valid), 0);
      check_eq("rst_th", bus.th, 0);
      check_eq("rst_step_cnt", 32'(step_cnt), 0);
      check_eq("rst_done_err", {30'd0, done, err}, 0);
      rst_n = 1'b1;
      tick();
      bus.act_valid = 1'b1;
      repeat (2) tick();
      bus.act_valid = 1'b0;
      check_eq("idle_act_ready", 32'(bus.act_ready), 0);
      check_eq("idle_no_launch", n_thd, 0);

      // ---- one full step: thd after 9 cycles, th after 5
      do_init(32'h3F80_0000, 32'h0);
      check_eq("init_act_ready", 32'(bus.act_ready), 1);
      check_eq("init_th", bus.th, 32'h3F80_0000);
      check_eq("init_step_cnt", 32'(step_cnt), 0);
      handshake(32'h4000_0000);
      check_eq("launch_thd_ena", 32'(bus.thd_ena), 1);
      check_eq("launch_thd_tor", bus.thd_tor, 32'h4000_0000);
      check_eq("launch_thd_th", bus.thd_th, 32'h3F80_0000);
      check_eq("launch_act_ready", 32'(bus.act_ready), 0);
      tick();
      check_eq("thd_ena_one_cycle", 32'(bus.thd_ena), 0);
      repeat (7) tick();
      thd_result(32'h3F4C_CCCD);
      check_eq("th_ena", 32'(bus.th_ena), 1);
      check_eq("th_thdot_shadow", bus.th_thdot, 32'h3F4C_CCCD);
      check_eq("th_not_committed", bus.thdot, 32'h0);
      repeat (4) tick();
      th_result(32'h3F8A_3D71);
      check_eq("obs_valid", 32'(bus.obs_valid), 1);
      check_eq("commit_th", bus.th, 32'h3F8A_3D71);
      check_eq("commit_thdot", bus.thdot, 32'h3F4C_CCCD);
      check_eq("step_cnt_1", 32'(step_cnt), 1);
      check_eq("one_thd_launch", n_thd, 1);
      check_eq("one_th_launch", n_th, 1);

      // ---- observation stall
      hold_bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.obs_valid !== 1'b1 || bus.th !== 32'h3F8A_3D71) hold_bad++;
      end
      check_eq("obs_hold_stable", hold_bad, 0);
      check_eq("obs_hold_no_launch", n_thd + n_th, 2);
      obs_ack();
      check_eq("obs_ack_valid", 32'(bus.obs_valid), 0);
      check_eq("obs_ack_ready", 32'(bus.act_ready), 1);

      // ---- episode end at 3 steps
      run_step(32'hBF80_0000, 32'h3E80_0000, 32'h3F90_0000);
      check_eq("step_cnt_2", 32'(step_cnt), 2);
      check_eq("done_not_yet", 32'(done), 0);
      run_step(32'h0, 32'h3F00_0000, 32'h3FA0_0000);
      check_eq("step_cnt_3", 32'(step_cnt), 3);
      check_eq("done_set", 32'(done), 1);
      snap_thd = n_thd;
      bus.act_valid = 1'b1;
      repeat (2) tick();
      bus.act_valid = 1'b0;
      check_eq("done_act_refused", 32'(bus.act_ready), 0);
      check_eq("done_no_launch", n_thd, snap_thd);

      // ---- abort in RUN_THD, stale result 3 cycles later
      do_init(32'h4040_0000, 32'h3F00_0000);
      check_eq("restart_done_clr", 32'(done), 0);
      check_eq("restart_step_cnt", 32'(step_cnt), 0);
      handshake(32'hBF80_0000);
      tick();
      snap_th = n_th;
      do_init(32'h4040_0000, 32'h3F00_0000);
      tick(); tick();
      thd_result(32'h4100_0000);
      check_eq("stale_th_ena", 32'(bus.th_ena), 0);
      check_eq("stale_wait_act", 32'(bus.act_ready), 1);
      check_eq("stale_step_cnt", 32'(step_cnt), 0);
      tick();
      check_eq("stale_no_th_launch", n_th, snap_th);

      // ---- abort, relaunch, stale result lands inside the new RUN_THD
      handshake(32'h3F00_0000);
      tick();
      do_init(32'h4040_0000, 32'h3F00_0000);
      handshake(32'h3F00_0000);
      thd_result(32'hC100_0000);
      check_eq("late_stale_dropped", 32'(bus.th_ena), 0);
      thd_result(32'h3E00_0000);
      check_eq("late_real_taken", 32'(bus.th_ena), 1);
      check_eq("late_real_thdot", bus.th_thdot, 32'h3E00_0000);
      tick();
      th_result(32'h4049_0FDB);
      check_eq("late_commit_th", bus.th, 32'h4049_0FDB);
      check_eq("late_step_cnt", 32'(step_cnt), 1);
      obs_ack();

      // ---- init and action in the same cycle
      snap_thd = n_thd;
      init_th = 32'h0; init_thdot = 32'h0; init = 1'b1;
      bus.tor = 32'h4000_0000; bus.act_valid = 1'b1;
      tick();
      init = 1'b0; bus.act_valid = 1'b0;
      check_eq("collide_no_ena", 32'(bus.thd_ena), 0);
      check_eq("collide_ready", 32'(bus.act_ready), 1);
      check_eq("collide_step_cnt", 32'(step_cnt), 0);
      tick();
      check_eq("collide_no_launch", n_thd, snap_thd);

      // ---- no thdot result after launch
      handshake(32'h4000_0000);
      check_eq("wd_launch", 32'(bus.thd_ena), 1);
      repeat (63) tick();
      check_eq("wd_err_cycle63", 32'(err), 0);
      tick();
      snap_th = n_th;
`ifdef PENDULUM_WATCHDOG_EN
      check_eq("wd_err_cycle64", 32'(err), 1);
      do_init(32'h0, 32'h0);
      check_eq("err_init_ignored", 32'(bus.act_ready), 0);
      check_eq("err_sticky", 32'(err), 1);
      thd_result(32'h3F00_0000);
      check_eq("err_result_ignored", 32'(bus.th_ena), 0);
`else
      check_eq("nowd_err_cycle64", 32'(err), 0);
      check_eq("nowd_still_waiting", 32'(bus.act_ready), 0);
      thd_result(32'h3F00_0000);
      check_eq("nowd_late_result", 32'(bus.th_ena), 1);
`endif

      // ---- reset asserted in RUN_TH
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      do_init(32'h3F80_0000, 32'h4000_0000);
      handshake(32'h3F80_0000);
      thd_result(32'h3F00_0000);
      check_eq("pre_rst_th_ena", 32'(bus.th_ena), 1);
      tick();
      rst_n = 1'b0;
      #2;
      check_eq("async_rst_th", bus.th, 0);
      check_eq("async_rst_thdot", bus.thdot, 0);
      check_eq("async_rst_shadow", bus.th_thdot, 0);
      check_eq("async_rst_tor", bus.thd_tor, 0);
      check_eq("async_rst_flags", {28'd0, bus.obs_valid, bus.act_ready, done, err}, 0);
      check_eq("async_rst_step_cnt", 32'(step_cnt), 0);
      snap_thd = n_thd;
      snap_th = n_th;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      th_result(32'h3F80_0000);
      check_eq("post_rst_no_obs", 32'(bus.obs_valid), 0);
      bus.act_valid = 1'b1;
      repeat (3) tick();
      bus.act_valid = 1'b0;
      check_eq("post_rst_no_launch", n_thd + n_th, snap_thd + snap_th);
      check_eq("post_rst_ready", 32'(bus.act_ready), 0);
      do_init(32'h0, 32'h0);
      handshake(32'h4000_0000);
      check_eq("post_rst_relaunch", 32'(bus.thd_ena), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
